// File: rtl/store_drain_buffer_pkg.sv
// Purpose : shared types and constants for the post-commit store drain buffer.
// Latency : n/a (types, constants and a pure byte-merge helper only).
// Backpr. : n/a.
//
// Contents: sdb_entry_t buffer entry, IO_PAGE default, merge_bytes() byte-lane merge.
package store_drain_buffer_pkg;

   // addr[31:24] value that routes a store to the IO port instead of data memory.
   localparam logic [7:0] IO_PAGE = 8'hFF;

   typedef struct packed {
      logic        valid;
      logic        io;     // captured at push from the address page
      logic [29:0] addr;   // word address
      logic [31:0] data;
      logic [3:0]  mask;   // byte write enables
   } sdb_entry_t;

   // Bytes enabled in new_m replace the corresponding bytes of old_d.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  new_m);
      logic [31:0] res;
      res = old_d;
      for (int b = 0; b < 4; b++) begin
         if (new_m[b]) res[8*b +: 8] = new_d[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sdb_fwd_lookup.sv
// Purpose : combinational store-to-load forwarding scan over the drain buffer.
// Latency : 0 cycles (purely combinational; the parent registers the result).
// Backpr. : none; evaluated every cycle.
//
// Ports: entries (buffer array), head, count (occupancy window), ld_addr (word address)
//        -> fwd_data (merged bytes), fwd_mask (bytes supplied).
module sdb_fwd_lookup
   import store_drain_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  sdb_entry_t [DEPTH-1:0]       entries,
   input  logic [$clog2(DEPTH)-1:0]     head,
   input  logic [$clog2(DEPTH):0]       count,
   input  logic [29:0]                  ld_addr,
   output logic [31:0]                  fwd_data,
   output logic [3:0]                   fwd_mask
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;

   // Walk oldest -> youngest so that a younger matching store overwrites older bytes.
   always_comb begin
      fwd_data = '0;
      fwd_mask = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && entries[idx].valid && (entries[idx].addr == ld_addr)) begin
            fwd_data = merge_bytes(fwd_data, entries[idx].data, entries[idx].mask);
            fwd_mask = fwd_mask | entries[idx].mask;
         end
      end
   end

   // The IO flag plays no part in forwarding.
   logic [DEPTH-1:0] io_bits;
   for (genvar g = 0; g < DEPTH; g++) begin : g_io
      assign io_bits[g] = entries[g].io;
   end
   logic unused_io;
   assign unused_io = ^io_bits;

endmodule

// File: rtl/store_drain_buffer.sv
// Purpose : post-commit write buffer; drains committed stores in order to data memory or IO.
// Latency : a push is presented on the drain port no earlier than the next cycle; forwarding is registered (1 cycle).
// Backpr. : no input backpressure; OUT_stall asserts at DEPTH-1 entries, drain ports hold the head while !ready.
//
// Ports: clk, rst (sync, active-high); IN_st* committed store; OUT_stall/OUT_ioBusy/OUT_empty status;
//        OUT_mem*/IN_memReady data-memory write port; OUT_io*/IN_ioReady IO write port;
//        IN_ldValid/IN_ldAddr/IN_stallLd load lookup -> OUT_fwdData/OUT_fwdMask.
// Build option: STORE_MERGE_EN merges a non-IO store into the youngest entry on a word-address match.
module store_drain_buffer
   import store_drain_buffer_pkg::*;
#(
   parameter int         DEPTH   = 4,
   parameter logic [7:0] IO_PAGE = store_drain_buffer_pkg::IO_PAGE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IN_stValid,
   input  logic [31:0] IN_stAddr,
   input  logic [31:0] IN_stData,
   input  logic [3:0]  IN_stMask,
   output logic        OUT_stall,
   output logic        OUT_ioBusy,
   output logic        OUT_empty,
   output logic        OUT_memValid,
   output logic [29:0] OUT_memAddr,
   output logic [31:0] OUT_memData,
   output logic [3:0]  OUT_memMask,
   input  logic        IN_memReady,
   output logic        OUT_ioValid,
   output logic [29:0] OUT_ioAddr,
   output logic [31:0] OUT_ioData,
   output logic [3:0]  OUT_ioMask,
   input  logic        IN_ioReady,
   input  logic        IN_ldValid,
   input  logic [29:0] IN_ldAddr,
   input  logic        IN_stallLd,
   output logic [31:0] OUT_fwdData,
   output logic [3:0]  OUT_fwdMask
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sdb_entry_t [DEPTH-1:0] ent;
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       count_nxt;
   logic                   io_inflight;
   logic                   empty_q;
   logic [31:0]            fwd_data_q;
   logic [3:0]             fwd_mask_q;

   sdb_entry_t head_ent;
   sdb_entry_t new_ent;
   logic       in_io;
   logic       full;
   logic       mem_vld;
   logic       io_vld;
   logic       pop;
   logic       push;
   logic       drop;
   logic       merge_hit;
   logic       io_busy;
   logic [31:0] lk_data;
   logic [3:0]  lk_mask;

   assign head_ent = ent[head];
   assign in_io    = (IN_stAddr[31:24] == IO_PAGE);
   assign full     = (count == CNT_W'(DEPTH));

   assign new_ent = '{valid: 1'b1, io: in_io, addr: IN_stAddr[31:2], data: IN_stData, mask: IN_stMask};

   // Only one port sees the head. An IO head waits while the previous IO write is still in flight.
   assign mem_vld = head_ent.valid & ~head_ent.io;
   assign io_vld  = head_ent.valid &  head_ent.io & ~io_inflight;
   assign pop     = (mem_vld & IN_memReady) | (io_vld & IN_ioReady);

`ifdef STORE_MERGE_EN
   logic [PTR_W-1:0] tail_m1;
   sdb_entry_t       youngest;

   assign tail_m1  = tail - PTR_W'(1);
   assign youngest = ent[tail_m1];

   // When a single entry remains it is also the head; it cannot absorb bytes on the cycle it leaves.
   assign merge_hit = IN_stValid & ~in_io & (count != '0) & youngest.valid & ~youngest.io &
                      (youngest.addr == IN_stAddr[31:2]) &
                      ~((count == CNT_W'(1)) & pop);
`else
   assign merge_hit = 1'b0;
`endif

   assign push = IN_stValid & ~merge_hit & ~full;
   assign drop = IN_stValid & ~merge_hit &  full;

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + CNT_W'(1);
      else if (!push && pop) count_nxt = count - CNT_W'(1);
   end

   always_comb begin
      io_busy = io_inflight;
      for (int i = 0; i < DEPTH; i++) begin
         io_busy = io_busy | (ent[i].valid & ent[i].io);
      end
   end

   // Lookup sees the buffer before this cycle's updates: same-cycle push invisible, popping head visible.
   sdb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_lookup (
      .entries  (ent),
      .head     (head),
      .count    (count),
      .ld_addr  (IN_ldAddr),
      .fwd_data (lk_data),
      .fwd_mask (lk_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ent         <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         io_inflight <= 1'b0;
         empty_q     <= 1'b1;
         fwd_data_q  <= '0;
         fwd_mask_q  <= '0;
      end else begin
         if (pop) begin
            ent[head].valid <= 1'b0;
            head            <= head + PTR_W'(1);
         end
         if (push) begin
            ent[tail] <= new_ent;
            tail      <= tail + PTR_W'(1);
         end
`ifdef STORE_MERGE_EN
         if (merge_hit) begin
            ent[tail_m1].data <= merge_bytes(youngest.data, IN_stData, IN_stMask);
            ent[tail_m1].mask <= youngest.mask | IN_stMask;
         end
`endif
         count       <= count_nxt;
         io_inflight <= io_vld & IN_ioReady;
         empty_q     <= (count_nxt == '0);
         if (!IN_stallLd) begin
            fwd_data_q <= lk_data;
            fwd_mask_q <= IN_ldValid ? lk_mask : 4'h0;
         end
      end
   end

   assign OUT_stall    = (count >= CNT_W'(DEPTH - 1));
   assign OUT_ioBusy   = io_busy;
   assign OUT_empty    = empty_q;
   assign OUT_memValid = mem_vld;
   assign OUT_memAddr  = head_ent.addr;
   assign OUT_memData  = head_ent.data;
   assign OUT_memMask  = head_ent.mask;
   assign OUT_ioValid  = io_vld;
   assign OUT_ioAddr   = head_ent.addr;
   assign OUT_ioData   = head_ent.data;
   assign OUT_ioMask   = head_ent.mask;
   assign OUT_fwdData  = fwd_data_q;
   assign OUT_fwdMask  = fwd_mask_q;

   // Byte offset within the word does not matter to a word-granular buffer.
   logic unused_addr_bits;
   assign unused_addr_bits = ^IN_stAddr[1:0];

   // The upstream slot reservation should make this unreachable; a dropped store is a protocol bug.
   assert property (@(posedge clk) disable iff (rst) !drop)
      else $error("store_drain_buffer: store dropped, buffer full");

endmodule
